d_branch_resolve_bht: RTL and testbench

Decode-stage branch resolution unit for the five-stage pipeline. It is the parametrised successor of the single-mode D-stage comparator. It evaluates all six conditional-branch conditions on WIDTH-bit operands, and it holds a DEPTH-entry branch history table of 2-bit saturating counters. The table gives a taken/not-taken prediction to F. Each D-stage branch outcome trains the table, and the unit flags mispredictions and keeps saturating statistics counters.

---
 rtl/branch_pkg.sv | 30 +++
 rtl/branch_cond.sv | 35 +++
 rtl/d_branch_resolve_bht.sv | 75 +++++++
 tb/tb_d_branch_resolve_bht.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch encodings, 2-bit BHT counter states and the counter update rule.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ    = 3'd0,
    BNE    = 3'd1,
    BLEZ   = 3'd2,
    BGTZ   = 3'd3,
    BLTZ   = 3'd4,
    BGEZ   = 3'd5,
    B_NONE = 3'd6
  } b_type_e;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational evaluator for the six conditional-branch conditions.
// Zero latency; types 6/7 always resolve not-taken.
module branch_cond
  import branch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [2:0]       b_type,
  output logic             taken
);

  logic rs_neg;
  logic rs_zero;
  logic rs_eq_rt;

  assign rs_neg   = rs[WIDTH-1];
  assign rs_zero  = (rs == '0);
  assign rs_eq_rt = (rs == rt);

  always_comb begin
    taken = 1'b0;
    case (b_type)
      BEQ:     taken = rs_eq_rt;
      BNE:     taken = !rs_eq_rt;
      BLEZ:    taken = rs_neg || rs_zero;
      BGTZ:    taken = !rs_neg && !rs_zero;
      BLTZ:    taken = rs_neg;
      BGEZ:    taken = !rs_neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/d_branch_resolve_bht.sv
// D-stage branch resolution with a 2-bit-counter BHT and saturating statistics.
// Prediction and compare are combinational; table/counter updates land one cycle after commit, held off while d_stall.
module d_branch_resolve_bht
  import branch_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter int         DEPTH    = 64,
  parameter int         CNT_W    = 16,
  parameter logic [1:0] INIT_CTR = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      f_pc,
  output logic             f_pred_taken,
  input  logic             d_valid,
  input  logic             d_stall,
  input  logic [31:0]      d_pc,
  input  logic [WIDTH-1:0] d_rs,
  input  logic [WIDTH-1:0] d_rt,
  input  logic [2:0]       d_b_type,
  input  logic             d_pred_taken,
  output logic             d_taken,
  output logic             d_mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]       bht [DEPTH];
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] d_idx;
  logic             cond_taken;
  logic             is_br;
  logic             commit;

  assign f_idx = f_pc[IDX_W+1:2];
  assign d_idx = d_pc[IDX_W+1:2];

  branch_cond #(.WIDTH(WIDTH)) u_cond (
    .rs     (d_rs),
    .rt     (d_rt),
    .b_type (d_b_type),
    .taken  (cond_taken)
  );

  assign is_br        = d_valid && (d_b_type < B_NONE);
  assign d_taken      = is_br && cond_taken;
  assign d_mispredict = is_br && (cond_taken != d_pred_taken);
  assign commit       = is_br && !d_stall;

  // Read is from the registered table, so a same-cycle write to this index is not visible yet.
  assign f_pred_taken = bht[f_idx][1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        bht[i] <= INIT_CTR;
      end
    end else if (commit) begin
      bht[d_idx] <= ctr_next(bht[d_idx], d_taken);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (commit) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
      if (d_mispredict && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_d_branch_resolve_bht.sv
// Scoreboard bench: driver pushes model expectations, negedge monitor pops and compares.
module tb_d_branch_resolve_bht;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] f_pc, d_pc, d_rs, d_rt;
  logic        d_valid, d_stall, d_pred_taken;
  logic [2:0]  d_b_type;

  logic        f_pred_taken, d_taken, d_mispredict;
  logic [15:0] branch_cnt, mispred_cnt;
  logic        f_pred4, d_taken4, d_mis4;
  logic [3:0]  branch_cnt4, mispred_cnt4;

  always #5 clk = ~clk;

  d_branch_resolve_bht u_dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .d_valid(d_valid), .d_stall(d_stall), .d_pc(d_pc), .d_rs(d_rs), .d_rt(d_rt),
    .d_b_type(d_b_type), .d_pred_taken(d_pred_taken), .d_taken(d_taken),
    .d_mispredict(d_mispredict), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  d_branch_resolve_bht #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_pred_taken(f_pred4),
    .d_valid(d_valid), .d_stall(d_stall), .d_pc(d_pc), .d_rs(d_rs), .d_rt(d_rt),
    .d_b_type(d_b_type), .d_pred_taken(d_pred_taken), .d_taken(d_taken4),
    .d_mispredict(d_mis4), .branch_cnt(branch_cnt4), .mispred_cnt(mispred_cnt4)
  );

  typedef struct {
    bit taken;
    bit mis;
    bit fpred;
    int bc;
    int mc;
    int bc4;
    int mc4;
  } exp_t;

  exp_t q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  // Reference model: table of counters as plain integers 0..3.
  int ctr [64];
  int m_bc, m_mc, m_bc4, m_mc4;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit ref_taken(input logic [31:0] rs, input logic [31:0] rt, input int bt);
    case (bt)
      0: return rs == rt;
      1: return rs != rt;
      2: return $signed(rs) <= 0;
      3: return $signed(rs) > 0;
      4: return $signed(rs) < 0;
      5: return $signed(rs) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ctr[i] = 1;
    m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("d_taken", d_taken, e.taken);
      chk("d_mispredict", d_mispredict, e.mis);
      chk("f_pred_taken", f_pred_taken, e.fpred);
      chk("branch_cnt", branch_cnt, e.bc);
      chk("mispred_cnt", mispred_cnt, e.mc);
      chk("f_pred_taken_w4", f_pred4, e.fpred);
      chk("d_mispredict_w4", d_mis4, e.mis);
      chk("branch_cnt_w4", branch_cnt4, e.bc4);
      chk("mispred_cnt_w4", mispred_cnt4, e.mc4);
    end
  end

  // One cycle: apply inputs after the edge, set reset level mid-cycle, push expectation, advance model.
  task automatic step(input logic [31:0] fpc, input logic [31:0] dpc, input logic [31:0] rs,
                      input logic [31:0] rt, input logic v, input logic s, input logic p,
                      input logic [2:0] bt, input logic r);
    exp_t e;
    bit   isbr, tk;
    int   di;
    @(posedge clk);
    #1;
    f_pc = fpc; d_pc = dpc; d_rs = rs; d_rt = rt;
    d_valid = v; d_stall = s; d_pred_taken = p; d_b_type = bt;
    #2;
    reset = r;
    if (r) model_reset();
    isbr    = v && (bt < 3'd6);
    tk      = isbr && ref_taken(rs, rt, int'(bt));
    e.taken = tk;
    e.mis   = isbr && (tk != p);
    e.fpred = ctr[idx_of(fpc)] >= 2;
    e.bc = m_bc; e.mc = m_mc; e.bc4 = m_bc4; e.mc4 = m_mc4;
    q.push_back(e);
    if (isbr && !s && !r) begin
      di = idx_of(dpc);
      ctr[di] = tk ? ((ctr[di] + 1 > 3) ? 3 : ctr[di] + 1) : ((ctr[di] - 1 < 0) ? 0 : ctr[di] - 1);
      if (m_bc < 65535) m_bc++;
      if (m_bc4 < 15) m_bc4++;
      if (e.mis) begin
        if (m_mc < 65535) m_mc++;
        if (m_mc4 < 15) m_mc4++;
      end
    end
  endtask

  task automatic br(input logic [31:0] fpc, input logic [31:0] dpc, input logic [2:0] bt,
                    input logic [31:0] rs, input logic [31:0] rt, input logic p, input logic s);
    step(fpc, dpc, rs, rt, 1'b1, s, p, bt, 1'b0);
  endtask

  task automatic idle(input logic [31:0] fpc);
    step(fpc, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b0);
  endtask

  logic [31:0] rnd_rs, rnd_rt, rnd_pc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    f_pc = '0; d_pc = '0; d_rs = '0; d_rt = '0;
    d_valid = 1'b0; d_stall = 1'b0; d_pred_taken = 1'b0; d_b_type = 3'd6;
    model_reset();

    // Reset state, with compare outputs following inputs while in reset.
    step(32'h3000, 32'h3000, 32'h1234, 32'h1234, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    step(32'h3000, 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1);
    idle(32'h3000);

    // Compare sweep, stalled so the table is untouched.
    br(32'h100, 32'h100, 3'd0, 32'h1234, 32'h1234, 1'b0, 1'b1);
    br(32'h100, 32'h100, 3'd1, 32'h1234, 32'h1234, 1'b1, 1'b1);
    br(32'h100, 32'h100, 3'd2, 32'h0, 32'h5, 1'b0, 1'b1);
    br(32'h100, 32'h100, 3'd3, 32'h0, 32'h5, 1'b1, 1'b1);
    br(32'h100, 32'h100, 3'd4, 32'h8000_0000, 32'h0, 1'b0, 1'b1);
    br(32'h100, 32'h100, 3'd5, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1);
    br(32'h100, 32'h100, 3'd6, 32'h0, 32'h0, 1'b1, 1'b1);
    br(32'h100, 32'h100, 3'd7, 32'h0, 32'h0, 1'b1, 1'b1);

    // Training at 0x3000: three taken, then one not-taken.
    idle(32'h3000);
    for (int i = 0; i < 3; i++) br(32'h3000, 32'h3000, 3'd0, 32'h5, 32'h5, 1'b0, 1'b0);
    br(32'h3000, 32'h3000, 3'd1, 32'h5, 32'h5, 1'b1, 1'b0);
    idle(32'h3000);

    // Stall for three cycles, then a single commit when it drops.
    for (int i = 0; i < 3; i++) br(32'h3080, 32'h3080, 3'd0, 32'h9, 32'h9, 1'b0, 1'b1);
    br(32'h3080, 32'h3080, 3'd0, 32'h9, 32'h9, 1'b0, 1'b0);
    idle(32'h3080);

    // Mispredict, then the same operands with no valid instruction.
    br(32'h3000, 32'h3010, 3'd1, 32'h1, 32'h2, 1'b0, 1'b0);
    step(32'h3000, 32'h3010, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
    idle(32'h3010);

    // Read/write collision at 0x3040: pre-update value this cycle, updated next.
    br(32'h3040, 32'h3040, 3'd3, 32'h7, 32'h0, 1'b0, 1'b0);
    idle(32'h3040);

    // Reset mid-stall discards the pending branch; clears predictions and counters.
    br(32'h3000, 32'h3000, 3'd0, 32'h3, 32'h3, 1'b0, 1'b1);
    step(32'h3000, 32'h3000, 32'h3, 32'h3, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1);
    step(32'h3000, 32'h3000, 32'h3, 32'h3, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(32'h3000);

    // Twenty commits: the 4-bit instance saturates at 15.
    for (int i = 0; i < 20; i++) br(32'h3000, 32'h3000, 3'd4, 32'hFFFF_FFF0, 32'h0, i[0], 1'b0);
    idle(32'h3000);

    // Randomized traffic with aliasing PCs and occasional resets.
    for (int i = 0; i < 400; i++) begin
      rnd_rt = $urandom;
      case ($urandom_range(0, 4))
        0: rnd_rs = 32'h0;
        1: rnd_rs = rnd_rt;
        2: rnd_rs = 32'h8000_0000;
        3: rnd_rs = 32'h7FFF_FFFF;
        default: rnd_rs = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0: rnd_pc = 32'h3000;
        1: rnd_pc = 32'h3100;
        2: rnd_pc = 32'h3040;
        default: rnd_pc = {$urandom} & 32'hFFFF_FFFC;
      endcase
      step(($urandom_range(0, 1) != 0) ? rnd_pc : 32'h3000, rnd_pc, rnd_rs, rnd_rt,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 49) == 0));
    end
    idle(32'h3000);

    @(posedge clk);
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
